// File: rtl/ip_rx_pkg.sv
// Shared constants and FSM state type for the IPv4 receive parsers.
package ip_rx_pkg;

    localparam logic [3:0]  IP_VER4       = 4'd4;
    localparam logic [7:0]  IP_PROTO_ICMP = 8'd1;
    localparam logic [3:0]  IP_MIN_IHL    = 4'd5;
    localparam logic [15:0] ICMP_MIN_LEN  = 16'd8;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAY,
        DROP
    } rx_state_t;

endpackage

// File: rtl/ip_hdr_csum.sv
// IPv4-style header checksum: clear / accumulate-byte / fold.
// Even bytes are the high octet of a 16-bit word, odd bytes the low octet.
// The folded result and pass flag include the byte presented this cycle,
// so a caller can decide on the last header byte without an extra cycle.
module ip_hdr_csum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        acc,
    input  logic        odd,
    input  logic [7:0]  dat,
    output logic [15:0] result,
    output logic        pass
);

    logic [20:0] sum_reg;
    logic [20:0] sum_next;
    logic [15:0] addend;
    logic [16:0] fold1;

    // Next accumulator value: optional clear, then add the current byte in its word lane
    always_comb begin
        addend   = odd ? {8'h00, dat} : {dat, 8'h00};
        sum_next = (clr ? 21'd0 : sum_reg) + (acc ? {5'd0, addend} : 21'd0);
        fold1    = {1'b0, sum_next[15:0]} + {12'd0, sum_next[20:16]};
        result   = fold1[15:0] + {15'd0, fold1[16]};
        pass     = (result == 16'hFFFF);
    end

    // Accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg <= 21'd0;
        end else begin
            sum_reg <= sum_next;
        end
    end

endmodule

// File: rtl/ip_rx_icmp_filter.sv
// IPv4 receive filter: parses/validates the IP header and forwards only the
// ICMP payload of packets addressed to this device to icmp_top.
// Optional build macro IP_RX_ICMP_BCAST_EN also accepts limited (255.255.255.255)
// and subnet ({local_ip[31:8],8'hFF}) broadcast destinations.
module ip_rx_icmp_filter
    import ip_rx_pkg::*;
#(
    parameter int D            = 2,
    parameter int MAX_ICMP_LEN = 128
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [31:0] local_ip,
    input  logic [47:0] ip_rx_src_mac,
    input  logic        ip_rx_sop,
    input  logic        ip_rx_eop,
    input  logic        ip_rx_vld,
    input  logic [7:0]  ip_rx_dat,
    output logic [15:0] ip_icmp_match_len,
    output logic [31:0] ip_icmp_match_ip,
    output logic [47:0] ip_icmp_match_mac,
    output logic        icmp_top_rx_sop,
    output logic        icmp_top_rx_eop,
    output logic        icmp_top_rx_vld,
    output logic [7:0]  icmp_top_rx_dat
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_ICMP_LEN);

    // D only shapes simulation delays in legacy flows; a negative value is meaningless
    if (D < 0) begin : g_invalid_delay
    end

    rx_state_t   state_reg, state_next;
    logic [5:0]  hdr_cnt_reg, hdr_cnt_next;
    logic [15:0] pay_cnt_reg, pay_cnt_next;
    logic        first_reg, first_next;

    logic [3:0]  ver_reg, ihl_reg;
    logic [15:0] total_len_reg;
    logic [13:0] frag_reg;
    logic [7:0]  proto_reg;
    logic [31:0] src_ip_reg, dst_ip_reg;
    logic [47:0] src_mac_reg;

    logic        sop_next, eop_next, vld_next;
    logic [7:0]  dat_next;

    logic        hdr_byte, hdr_last, accept, len_ok, dst_ok, csum_pass;
    logic [5:0]  byte_idx, hdr_len;
    logic [31:0] dst_ip_cur;
    logic [16:0] icmp_len_wide;
    logic [15:0] csum_result_unused;

    // Header decode: byte position, last-byte detect and accept conditions
    always_comb begin
        hdr_byte      = ip_rx_vld && (ip_rx_sop || state_reg == HDR);
        byte_idx      = ip_rx_sop ? 6'd0 : hdr_cnt_reg;
        hdr_len       = {ihl_reg, 2'b00};
        hdr_last      = ip_rx_vld && !ip_rx_sop && state_reg == HDR &&
                        hdr_cnt_reg == hdr_len - 6'd1;
        // Byte 19 completes dst_ip on the same cycle the decision is taken for IHL=5
        dst_ip_cur    = (hdr_cnt_reg == 6'd19) ? {dst_ip_reg[23:0], ip_rx_dat} : dst_ip_reg;
        icmp_len_wide = {1'b0, total_len_reg} - {11'd0, hdr_len};
        len_ok        = !icmp_len_wide[16] && icmp_len_wide[15:0] >= ICMP_MIN_LEN &&
                        icmp_len_wide[15:0] <= MAX_LEN;
`ifdef IP_RX_ICMP_BCAST_EN
        dst_ok        = (dst_ip_cur == local_ip) || (dst_ip_cur == 32'hFFFF_FFFF) ||
                        (dst_ip_cur == {local_ip[31:8], 8'hFF});
`else
        dst_ok        = (dst_ip_cur == local_ip);
`endif
        accept        = ver_reg == IP_VER4 && ihl_reg >= IP_MIN_IHL && csum_pass &&
                        proto_reg == IP_PROTO_ICMP && frag_reg == 14'd0 && dst_ok && len_ok;
    end

    // Header checksum over every header byte, restarted by sop
    ip_hdr_csum u_csum (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .clr    (ip_rx_vld && ip_rx_sop),
        .acc    (hdr_byte),
        .odd    (byte_idx[0]),
        .dat    (ip_rx_dat),
        .result (csum_result_unused),
        .pass   (csum_pass)
    );

    // Next-state, counters and forwarded-byte outputs
    always_comb begin
        state_next   = state_reg;
        hdr_cnt_next = hdr_cnt_reg;
        pay_cnt_next = pay_cnt_reg;
        first_next   = first_reg;
        sop_next     = 1'b0;
        eop_next     = 1'b0;
        vld_next     = 1'b0;
        dat_next     = 8'h00;
        if (ip_rx_vld) begin
            if (ip_rx_sop) begin
                // Restart parsing; an interrupted payload is closed with an abort marker
                eop_next   = (state_reg == PAY);
                first_next = 1'b0;
                if (ip_rx_eop) begin
                    state_next   = IDLE;
                    hdr_cnt_next = 6'd0;
                end else begin
                    state_next   = HDR;
                    hdr_cnt_next = 6'd1;
                end
            end else begin
                case (state_reg)
                    IDLE: state_next = IDLE;
                    HDR: begin
                        hdr_cnt_next = hdr_cnt_reg + 6'd1;
                        if (ip_rx_eop) begin
                            state_next = IDLE;
                        end else if (hdr_last) begin
                            if (accept) begin
                                state_next   = PAY;
                                pay_cnt_next = icmp_len_wide[15:0];
                                first_next   = 1'b1;
                            end else begin
                                state_next = DROP;
                            end
                        end
                    end
                    PAY: begin
                        vld_next     = 1'b1;
                        dat_next     = ip_rx_dat;
                        sop_next     = first_reg;
                        first_next   = 1'b0;
                        pay_cnt_next = pay_cnt_reg - 16'd1;
                        if (pay_cnt_reg == 16'd1) begin
                            eop_next   = 1'b1;
                            state_next = ip_rx_eop ? IDLE : DROP;
                        end else if (ip_rx_eop) begin
                            eop_next   = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    DROP: if (ip_rx_eop) state_next = IDLE;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // FSM, counters and registered output stage
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg       <= IDLE;
            hdr_cnt_reg     <= 6'd0;
            pay_cnt_reg     <= 16'd0;
            first_reg       <= 1'b0;
            icmp_top_rx_sop <= 1'b0;
            icmp_top_rx_eop <= 1'b0;
            icmp_top_rx_vld <= 1'b0;
            icmp_top_rx_dat <= 8'h00;
        end else begin
            state_reg       <= state_next;
            hdr_cnt_reg     <= hdr_cnt_next;
            pay_cnt_reg     <= pay_cnt_next;
            first_reg       <= first_next;
            icmp_top_rx_sop <= sop_next;
            icmp_top_rx_eop <= eop_next;
            icmp_top_rx_vld <= vld_next;
            icmp_top_rx_dat <= dat_next;
        end
    end

    // Header field capture by byte position; sender MAC latched on sop
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ver_reg       <= 4'd0;
            ihl_reg       <= 4'd0;
            total_len_reg <= 16'd0;
            frag_reg      <= 14'd0;
            proto_reg     <= 8'd0;
            src_ip_reg    <= 32'd0;
            dst_ip_reg    <= 32'd0;
            src_mac_reg   <= 48'd0;
        end else if (hdr_byte) begin
            case (byte_idx)
                6'd0:  begin
                    {ver_reg, ihl_reg} <= ip_rx_dat;
                    src_mac_reg        <= ip_rx_src_mac;
                end
                6'd2:  total_len_reg[15:8] <= ip_rx_dat;
                6'd3:  total_len_reg[7:0]  <= ip_rx_dat;
                6'd6:  frag_reg[13:8]      <= ip_rx_dat[5:0];
                6'd7:  frag_reg[7:0]       <= ip_rx_dat;
                6'd9:  proto_reg           <= ip_rx_dat;
                6'd12, 6'd13, 6'd14, 6'd15: src_ip_reg <= {src_ip_reg[23:0], ip_rx_dat};
                6'd16, 6'd17, 6'd18, 6'd19: dst_ip_reg <= {dst_ip_reg[23:0], ip_rx_dat};
                default: ;
            endcase
        end
    end

    // Match information for icmp_top, updated only when a header is accepted
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ip_icmp_match_len <= 16'd0;
            ip_icmp_match_ip  <= 32'd0;
            ip_icmp_match_mac <= 48'd0;
        end else if (hdr_last && accept && !ip_rx_eop) begin
            ip_icmp_match_len <= total_len_reg;
            ip_icmp_match_ip  <= src_ip_reg;
            ip_icmp_match_mac <= src_mac_reg;
        end
    end

endmodule
